mem_scheduler: RTL and testbench

- Shares the single Wishbone-side memory port between four requesters: VGA pixel fetch, CPU instruction fetch, CPU data load/store, and UART write.
- Sits between the clients and the memory/Wishbone master. It replaces ad-hoc per-client muxing with one registered transaction FSM.
- VGA gets deadline priority while active. The other clients share the port round-robin, with a starvation cap on VGA bursts.

---
 rtl/mem_sched_pkg.sv | 26 ++
 rtl/mem_scheduler_if.sv | 24 ++
 rtl/mem_scheduler_rr_arbiter.sv | 33 +++
 rtl/mem_scheduler.sv | 249 ++++++++++++++++++++++++
 tb/tb_mem_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_sched_pkg.sv
// Shared types and constants for the memory-port scheduler.
// Client and state encodings used by the top and the round-robin arbiter.
package mem_sched_pkg;

  typedef enum logic [1:0] {
    VGA_INACTIVE = 2'b00,
    VGA_READY    = 2'b01,
    VGA_ACTIVE   = 2'b10
  } VGA_state_t;

  typedef enum logic [1:0] {VGA, INSTR, DATA, UART} client_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} sched_state_t;

  localparam logic [3:0] SEL_FULL = 4'b1111;

  // Round-robin slot 0/1/2 serves INSTR/DATA/UART.
  function automatic client_t rr_to_client(input logic [1:0] idx);
    case (idx)
      2'd0:    return INSTR;
      2'd1:    return DATA;
      default: return UART;
    endcase
  endfunction

endpackage

// File: rtl/mem_scheduler_if.sv
// Memory-side bus of the scheduler: strobes, address, data, select and busy.
// master = scheduler, slave = memory / Wishbone master.
interface mem_scheduler_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_busy;
  logic [DATA_W-1:0] data_from_mem;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] adr_to_mem;
  logic [DATA_W-1:0] data_to_mem;
  logic [3:0]        sel_to_mem;

  modport master (
    input  mem_busy, data_from_mem,
    output mem_read, mem_write, adr_to_mem, data_to_mem, sel_to_mem
  );

  modport slave (
    output mem_busy, data_from_mem,
    input  mem_read, mem_write, adr_to_mem, data_to_mem, sel_to_mem
  );
endinterface

// File: rtl/mem_scheduler_rr_arbiter.sv
// Three-way round-robin arbiter over the non-VGA clients.
// ptr holds the slot with highest priority; it moves past each accepted grant.
module rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       accept,
  output logic       valid,
  output logic [1:0] grant_idx
);

  logic [1:0] ptr;
  logic [1:0] c1, c2;

  function automatic logic [1:0] nxt(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  always_comb begin
    c1    = nxt(ptr);
    c2    = nxt(c1);
    valid = |req;
    if (req[ptr])     grant_idx = ptr;
    else if (req[c1]) grant_idx = c1;
    else              grant_idx = c2;
  end

  always_ff @(posedge clk) begin
    if (rst)                  ptr <= 2'd0;
    else if (accept && valid) ptr <= nxt(grant_idx);
  end

endmodule

// File: rtl/mem_scheduler.sv
// Single-port memory scheduler: VGA deadline priority with a burst cap,
// round robin for CPU instruction, CPU data and UART; one registered FSM.
module mem_scheduler
  import mem_sched_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_VGA_BURST = 4,
  parameter int BUSY_TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic [1:0]        VGA_state,
  input  logic              VGA_read,
  input  logic [ADDR_W-1:0] VGA_adr,
  output logic [DATA_W-1:0] data_to_VGA,
  output logic              VGA_ack,
  input  logic              CPU_instr_req,
  input  logic [ADDR_W-1:0] CPU_instr_adr,
  output logic [DATA_W-1:0] instr_data_to_CPU,
  output logic              CPU_instr_ack,
  input  logic              CPU_read,
  input  logic              CPU_write,
  input  logic [ADDR_W-1:0] CPU_data_adr,
  input  logic [DATA_W-1:0] data_from_CPU,
  input  logic [3:0]        CPU_sel,
  output logic [DATA_W-1:0] data_to_CPU,
  output logic              CPU_data_ack,
  input  logic              UART_write,
  input  logic [ADDR_W-1:0] UART_adr,
  input  logic [DATA_W-1:0] data_from_UART,
  output logic              UART_ack,
  mem_scheduler_if.master   mem,
  output logic              err
);

  localparam int BURST_W = $clog2(MAX_VGA_BURST + 1);
  localparam int TMO_W   = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_VGA_BURST);
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(BUSY_TIMEOUT - 1);

  sched_state_t        state, state_n;
  client_t             cli, cli_n, rr_cli;
  logic                rd_q, rd_n;
  logic [BURST_W-1:0]  burst, burst_n;
  logic [TMO_W-1:0]    tmo, tmo_n;

  logic [DATA_W-1:0]   dv_n, di_n, dc_n;
  logic                vga_ack_n, instr_ack_n, data_ack_n, uart_ack_n, err_n;
  logic                mr_n, mw_n;
  logic [ADDR_W-1:0]   adr_n;
  logic [DATA_W-1:0]   wd_n;
  logic [3:0]          sel_n;

  logic                vga_ok, nonvga_pend, clr, ack_any;
  logic [2:0]          rr_req;
  logic                rr_accept, rr_valid;
  logic [1:0]          rr_idx;

  assign rr_req      = {UART_write, CPU_read | CPU_write, CPU_instr_req};
  assign nonvga_pend = |rr_req;
  assign vga_ok      = VGA_read && (VGA_state != VGA_INACTIVE);
  assign rr_cli      = rr_to_client(rr_idx);

  rr_arbiter u_rr (
    .clk       (clk),
    .rst       (Rst),
    .req       (rr_req),
    .accept    (rr_accept),
    .valid     (rr_valid),
    .grant_idx (rr_idx)
  );

  always_comb begin
    state_n     = state;
    cli_n       = cli;
    rd_n        = rd_q;
    burst_n     = burst;
    tmo_n       = tmo;
    dv_n        = data_to_VGA;
    di_n        = instr_data_to_CPU;
    dc_n        = data_to_CPU;
    vga_ack_n   = 1'b0;
    instr_ack_n = 1'b0;
    data_ack_n  = 1'b0;
    uart_ack_n  = 1'b0;
    err_n       = 1'b0;
    mr_n        = mem.mem_read;
    mw_n        = mem.mem_write;
    adr_n       = mem.adr_to_mem;
    wd_n        = mem.data_to_mem;
    sel_n       = mem.sel_to_mem;
    rr_accept   = 1'b0;
    clr         = 1'b0;
    ack_any     = 1'b0;

    case (state)
      IDLE: begin
        // Past the burst cap VGA still wins when nobody else is waiting.
        if (vga_ok && ((burst < BURST_MAX) || !nonvga_pend)) begin
          state_n = ISSUE;
          cli_n   = VGA;
          rd_n    = 1'b1;
          mr_n    = 1'b1;
          adr_n   = VGA_adr;
          wd_n    = '0;
          sel_n   = SEL_FULL;
          if (burst < BURST_MAX) burst_n = burst + BURST_W'(1);
        end else if (rr_valid) begin
          state_n   = ISSUE;
          rr_accept = 1'b1;
          burst_n   = '0;
          cli_n     = rr_cli;
          case (rr_cli)
            INSTR: begin
              rd_n  = 1'b1;
              mr_n  = 1'b1;
              adr_n = CPU_instr_adr;
              wd_n  = '0;
              sel_n = SEL_FULL;
            end
            DATA: begin
              rd_n = 1'b0;
              if (CPU_sel != 4'b0000) begin
                adr_n = CPU_data_adr;
                sel_n = CPU_sel;
                if (CPU_write) begin
                  mw_n = 1'b1;
                  wd_n = data_from_CPU;
                end else begin
                  rd_n = 1'b1;
                  mr_n = 1'b1;
                  wd_n = '0;
                end
              end
            end
            default: begin
              rd_n  = 1'b0;
              mw_n  = 1'b1;
              adr_n = UART_adr;
              wd_n  = data_from_UART;
              sel_n = SEL_FULL;
            end
          endcase
        end
      end
      ISSUE: begin
        // No strobe means a zero-select data access: ack without touching memory.
        if (!(mem.mem_read || mem.mem_write)) begin
          ack_any = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = WAIT_BUSY;
          tmo_n   = '0;
        end
      end
      WAIT_BUSY: begin
        if (mem.mem_busy) begin
          clr     = 1'b1;
          state_n = WAIT_DONE;
          tmo_n   = '0;
        end else if (tmo == TMO_LAST) begin
          err_n   = 1'b1;
          ack_any = 1'b1;
          clr     = 1'b1;
          state_n = IDLE;
          tmo_n   = '0;
        end else begin
          tmo_n = tmo + TMO_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!mem.mem_busy) begin
          ack_any = 1'b1;
          state_n = IDLE;
          if (rd_q) begin
            case (cli)
              VGA:     dv_n = mem.data_from_mem;
              INSTR:   di_n = mem.data_from_mem;
              DATA:    dc_n = mem.data_from_mem;
              default: ;
            endcase
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (clr) begin
      mr_n  = 1'b0;
      mw_n  = 1'b0;
      adr_n = '0;
      wd_n  = '0;
      sel_n = '0;
    end

    if (ack_any) begin
      case (cli)
        VGA:     vga_ack_n   = 1'b1;
        INSTR:   instr_ack_n = 1'b1;
        DATA:    data_ack_n  = 1'b1;
        default: uart_ack_n  = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state             <= IDLE;
      cli               <= VGA;
      rd_q              <= 1'b0;
      burst             <= '0;
      tmo               <= '0;
      data_to_VGA       <= '0;
      instr_data_to_CPU <= '0;
      data_to_CPU       <= '0;
      VGA_ack           <= 1'b0;
      CPU_instr_ack     <= 1'b0;
      CPU_data_ack      <= 1'b0;
      UART_ack          <= 1'b0;
      err               <= 1'b0;
      mem.mem_read      <= 1'b0;
      mem.mem_write     <= 1'b0;
      mem.adr_to_mem    <= '0;
      mem.data_to_mem   <= '0;
      mem.sel_to_mem    <= '0;
    end else begin
      state             <= state_n;
      cli               <= cli_n;
      rd_q              <= rd_n;
      burst             <= burst_n;
      tmo               <= tmo_n;
      data_to_VGA       <= dv_n;
      instr_data_to_CPU <= di_n;
      data_to_CPU       <= dc_n;
      VGA_ack           <= vga_ack_n;
      CPU_instr_ack     <= instr_ack_n;
      CPU_data_ack      <= data_ack_n;
      UART_ack          <= uart_ack_n;
      err               <= err_n;
      mem.mem_read      <= mr_n;
      mem.mem_write     <= mw_n;
      mem.adr_to_mem    <= adr_n;
      mem.data_to_mem   <= wd_n;
      mem.sel_to_mem    <= sel_n;
    end
  end

endmodule

// File: tb/tb_mem_scheduler.sv
// Directed bench for mem_scheduler: table of single transactions plus
// hand-written sequences for reset, round robin, VGA burst cap, zero select and timeout.
module tb_mem_scheduler;

  logic        clk;
  logic        Rst;
  logic [1:0]  VGA_state;
  logic        VGA_read;
  logic [31:0] VGA_adr;
  logic [31:0] data_to_VGA;
  logic        VGA_ack;
  logic        CPU_instr_req;
  logic [31:0] CPU_instr_adr;
  logic [31:0] instr_data_to_CPU;
  logic        CPU_instr_ack;
  logic        CPU_read;
  logic        CPU_write;
  logic [31:0] CPU_data_adr;
  logic [31:0] data_from_CPU;
  logic [3:0]  CPU_sel;
  logic [31:0] data_to_CPU;
  logic        CPU_data_ack;
  logic        UART_write;
  logic [31:0] UART_adr;
  logic [31:0] data_from_UART;
  logic        UART_ack;
  logic        err;

  mem_scheduler_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

  mem_scheduler #(
    .ADDR_W(32), .DATA_W(32), .MAX_VGA_BURST(4), .BUSY_TIMEOUT(16)
  ) dut (
    .clk               (clk),
    .Rst               (Rst),
    .VGA_state         (VGA_state),
    .VGA_read          (VGA_read),
    .VGA_adr           (VGA_adr),
    .data_to_VGA       (data_to_VGA),
    .VGA_ack           (VGA_ack),
    .CPU_instr_req     (CPU_instr_req),
    .CPU_instr_adr     (CPU_instr_adr),
    .instr_data_to_CPU (instr_data_to_CPU),
    .CPU_instr_ack     (CPU_instr_ack),
    .CPU_read          (CPU_read),
    .CPU_write         (CPU_write),
    .CPU_data_adr      (CPU_data_adr),
    .data_from_CPU     (data_from_CPU),
    .CPU_sel           (CPU_sel),
    .data_to_CPU       (data_to_CPU),
    .CPU_data_ack      (CPU_data_ack),
    .UART_write        (UART_write),
    .UART_adr          (UART_adr),
    .data_from_UART    (data_from_UART),
    .UART_ack          (UART_ack),
    .mem               (mem_if),
    .err               (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0]   acks;
  logic [69:0]  membus;
  logic [170:0] outs;
  assign acks   = {UART_ack, CPU_data_ack, CPU_instr_ack, VGA_ack};
  assign membus = {mem_if.mem_read, mem_if.mem_write, mem_if.sel_to_mem,
                   mem_if.adr_to_mem, mem_if.data_to_mem};
  assign outs   = {data_to_VGA, instr_data_to_CPU, data_to_CPU, acks, membus, err};

  typedef struct {
    logic [1:0]  cli;      // 0 VGA, 1 INSTR, 2 DATA, 3 UART
    logic [1:0]  vstate;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] rdata;
    int          nbusy;    // edges that see mem_busy=1
    logic        exp_rd;
    logic        exp_wr;
    logic [31:0] exp_dat;
    logic [3:0]  exp_sel;
    logic [1:0]  obs;      // held register to inspect: 0 VGA, 1 instr, 2 data
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] obs_val(input logic [1:0] o);
    case (o)
      2'd0:    return data_to_VGA;
      2'd1:    return instr_data_to_CPU;
      default: return data_to_CPU;
    endcase
  endfunction

  task automatic drop_all();
    VGA_read      = 1'b0;
    CPU_instr_req = 1'b0;
    CPU_read      = 1'b0;
    CPU_write     = 1'b0;
    UART_write    = 1'b0;
  endtask

  task automatic drive_req(input vec_t v);
    case (v.cli)
      2'd0: begin VGA_state = v.vstate; VGA_read = 1'b1; VGA_adr = v.adr; end
      2'd1: begin CPU_instr_req = 1'b1; CPU_instr_adr = v.adr; end
      2'd2: begin
        CPU_read = v.cpu_rd; CPU_write = v.cpu_wr; CPU_data_adr = v.adr;
        data_from_CPU = v.wdata; CPU_sel = v.sel;
      end
      default: begin UART_write = 1'b1; UART_adr = v.adr; data_from_UART = v.wdata; end
    endcase
  endtask

  // Memory model: busy for two edges, then drop with read data; ends in the ack cycle.
  task automatic do_txn(input logic [31:0] rdata);
    mem_if.mem_busy = 1'b1;
    tick();
    tick();
    mem_if.mem_busy      = 1'b0;
    mem_if.data_from_mem = rdata;
    tick();
  endtask

  task automatic do_reset();
    drop_all();
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] adr_seq [6];
    int n;

    vecs[0] = '{2'd0, 2'b10, 1'b0, 1'b0, 32'h000ABCDE, 32'h0, 4'hF, 32'hABCDE101, 3,
                1'b1, 1'b0, 32'h0, 4'hF, 2'd0, 32'hABCDE101};
    vecs[1] = '{2'd1, 2'b00, 1'b0, 1'b0, 32'h00001000, 32'h0, 4'hF, 32'h13000093, 2,
                1'b1, 1'b0, 32'h0, 4'hF, 2'd1, 32'h13000093};
    vecs[2] = '{2'd2, 2'b00, 1'b1, 1'b0, 32'h00002000, 32'h0, 4'b0101, 32'h55AA33CC, 2,
                1'b1, 1'b0, 32'h0, 4'b0101, 2'd2, 32'h55AA33CC};
    vecs[3] = '{2'd2, 2'b00, 1'b0, 1'b1, 32'h00002004, 32'h0000FAB1, 4'b0011, 32'hDEADBEEF, 4,
                1'b0, 1'b1, 32'h0000FAB1, 4'b0011, 2'd2, 32'h55AA33CC};
    vecs[4] = '{2'd2, 2'b00, 1'b1, 1'b1, 32'h00002008, 32'h12345678, 4'b1100, 32'hFFFFFFFF, 2,
                1'b0, 1'b1, 32'h12345678, 4'b1100, 2'd2, 32'h55AA33CC};
    vecs[5] = '{2'd3, 2'b00, 1'b0, 1'b0, 32'h30000000, 32'h00000041, 4'hF, 32'h0, 2,
                1'b0, 1'b1, 32'h00000041, 4'hF, 2'd0, 32'hABCDE101};
    vecs[6] = '{2'd0, 2'b01, 1'b0, 1'b0, 32'h00000040, 32'h0, 4'hF, 32'h0BADF00D, 2,
                1'b1, 1'b0, 32'h0, 4'hF, 2'd0, 32'h0BADF00D};
    vecs[7] = '{2'd1, 2'b00, 1'b0, 1'b0, 32'h00001004, 32'h0, 4'hF, 32'h00500513, 3,
                1'b1, 1'b0, 32'h0, 4'hF, 2'd1, 32'h00500513};

    VGA_state = 2'b00; VGA_adr = '0; CPU_instr_adr = '0; CPU_data_adr = '0;
    data_from_CPU = '0; CPU_sel = '0; UART_adr = '0; data_from_UART = '0;
    mem_if.mem_busy = 1'b0; mem_if.data_from_mem = '0;
    do_reset();
    chk("reset_outputs", 192'(outs), 192'(0));

    for (int i = 0; i < 8; i++) begin
      drive_req(vecs[i]);
      tick();
      chk($sformatf("v%0d_issue_bus", i), 192'(membus),
          192'({vecs[i].exp_rd, vecs[i].exp_wr, vecs[i].exp_sel, vecs[i].adr, vecs[i].exp_dat}));
      drop_all();
      mem_if.mem_busy = 1'b1;
      tick();
      chk($sformatf("v%0d_wait_busy_held", i), 192'(membus),
          192'({vecs[i].exp_rd, vecs[i].exp_wr, vecs[i].exp_sel, vecs[i].adr, vecs[i].exp_dat}));
      tick();
      chk($sformatf("v%0d_wait_done_bus", i), 192'(membus), 192'(0));
      for (int k = 3; k <= vecs[i].nbusy; k++) begin
        tick();
        chk($sformatf("v%0d_no_early_ack", i), 192'(acks), 192'(0));
      end
      mem_if.mem_busy      = 1'b0;
      mem_if.data_from_mem = vecs[i].rdata;
      tick();
      chk($sformatf("v%0d_ack", i), 192'(acks), 192'(4'b0001 << vecs[i].cli));
      chk($sformatf("v%0d_data_reg", i), 192'(obs_val(vecs[i].obs)), 192'(vecs[i].exp_out));
      mem_if.data_from_mem = '0;
      tick();
      chk($sformatf("v%0d_ack_single", i), 192'({acks, err}), 192'(0));
    end

    // Zero byte select: acked without a memory access, load register untouched.
    CPU_read = 1'b1; CPU_sel = 4'b0000; CPU_data_adr = 32'h0000200C;
    mem_if.data_from_mem = 32'hFFFFFFFF;
    tick();
    chk("zsel_no_strobe", 192'(membus), 192'(0));
    chk("zsel_no_ack_yet", 192'(acks), 192'(0));
    drop_all();
    tick();
    chk("zsel_ack", 192'(acks), 192'(4'b0100));
    chk("zsel_data_held", 192'(data_to_CPU), 192'(32'h55AA33CC));
    tick();
    chk("zsel_ack_single", 192'(acks), 192'(0));
    mem_if.data_from_mem = '0;

    // Busy timeout on a UART write.
    UART_write = 1'b1; UART_adr = 32'h30000004; data_from_UART = 32'h42;
    tick();
    chk("tmo_issue", 192'({mem_if.mem_write, mem_if.adr_to_mem}), 192'({1'b1, 32'h30000004}));
    drop_all();
    n = 0;
    while (!err && n < 40) begin
      tick();
      n++;
      if (n == 16) chk("tmo_strobe_held", 192'(mem_if.mem_write), 192'(1'b1));
    end
    chk("tmo_latency", 192'(n), 192'(17));
    chk("tmo_uart_ack_with_err", 192'(acks), 192'(4'b1000));
    chk("tmo_outputs_cleared", 192'(membus), 192'(0));
    chk("tmo_vga_data_held", 192'(data_to_VGA), 192'(32'h0BADF00D));
    tick();
    chk("tmo_pulse_single", 192'({acks, err}), 192'(0));

    // Reset asserted while waiting for busy abandons the transaction.
    VGA_state = 2'b10; VGA_read = 1'b1; VGA_adr = 32'h00000080;
    tick();
    drop_all();
    tick();
    chk("rst_mid_in_wait_busy", 192'(mem_if.mem_read), 192'(1'b1));
    Rst = 1'b1;
    tick();
    tick();
    chk("rst_mid_outputs", 192'(outs), 192'(0));
    Rst = 1'b0;
    tick();
    tick();
    chk("rst_mid_no_ack_idle", 192'(outs), 192'(0));

    // Round robin with all three non-VGA clients held.
    CPU_instr_req = 1'b1; CPU_instr_adr = 32'h00001100;
    CPU_write = 1'b1; CPU_sel = 4'b0011; data_from_CPU = 32'h0000FAB1; CPU_data_adr = 32'h00002100;
    UART_write = 1'b1; UART_adr = 32'h00003100; data_from_UART = 32'h55;
    adr_seq[0] = 32'h00001100; adr_seq[1] = 32'h00002100;
    adr_seq[2] = 32'h00003100; adr_seq[3] = 32'h00001100;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rr_grant%0d_adr", i), 192'(mem_if.adr_to_mem), 192'(adr_seq[i]));
      if (i == 1)
        chk("rr_data_write_bus", 192'({mem_if.mem_read, mem_if.mem_write, mem_if.sel_to_mem, mem_if.data_to_mem}),
            192'({1'b0, 1'b1, 4'b0011, 32'h0000FAB1}));
      do_txn(32'h11110000 + 32'(i));
      if (i == 3) drop_all();
    end
    chk("rr_last_ack_instr", 192'(acks), 192'(4'b0010));
    tick();

    // VGA burst cap: four VGA grants, one forced INSTR grant, then VGA again.
    do_reset();
    VGA_state = 2'b10; VGA_read = 1'b1; VGA_adr = 32'h00000A00;
    CPU_instr_req = 1'b1; CPU_instr_adr = 32'h00000B00;
    for (int i = 0; i < 6; i++) adr_seq[i] = (i == 4) ? 32'h00000B00 : 32'h00000A00;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("burst_grant%0d_adr", i), 192'(mem_if.adr_to_mem), 192'(adr_seq[i]));
      do_txn(32'hC0DE0000 + 32'(i));
      if (i == 5) drop_all();
    end
    chk("burst_vga_data", 192'(data_to_VGA), 192'(32'hC0DE0005));
    chk("burst_instr_data", 192'(instr_data_to_CPU), 192'(32'hC0DE0004));
    tick();

    // VGA inactive: read request is ignored.
    VGA_state = 2'b00; VGA_read = 1'b1; VGA_adr = 32'h00000C00;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("vga_inactive_idle%0d", i), 192'({mem_if.mem_read, acks}), 192'(0));
    end
    drop_all();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
